// File: rtl/vector_alu_pipe.sv
// Two-stage, multi-lane vector ALU with valid/ready input and valid/yumi output handshakes.
// Optional macro VECTOR_ALU_SATURATE_EN clamps add/sub results on signed overflow instead of wrapping.
module vector_alu_pipe #(
    parameter int vdw_p    = 32,
    parameter int lanes_p  = 4,
    parameter int op_len_p = 3
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [lanes_p*vdw_p-1:0]   a_i,
    input  logic [lanes_p*vdw_p-1:0]   b_i,
    input  logic [op_len_p-1:0]        op_i,
    input  logic [lanes_p-1:0]         mask_i,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic [lanes_p*vdw_p-1:0]   result_o,
    output logic [lanes_p-1:0]         overflow_o,
    output logic [lanes_p-1:0]         zero_o,
    output logic [lanes_p-1:0]         negative_o
);

    typedef enum logic [2:0] {
        op_add = 3'd0,
        op_sub = 3'd1,
        op_mul = 3'd2,
        op_min = 3'd3,
        op_max = 3'd4,
        op_and = 3'd5,
        op_or  = 3'd6,
        op_xor = 3'd7
    } alu_op_e;

    logic                     s1_valid;
    logic [lanes_p*vdw_p-1:0] s1_a;
    logic [lanes_p*vdw_p-1:0] s1_b;
    logic [op_len_p-1:0]      s1_op;
    logic [lanes_p-1:0]       s1_mask;

    logic                     s2_valid;
    logic                     stage2_free;
    logic                     accept;
    logic                     advance;
    alu_op_e                  op_code;

    logic [lanes_p*vdw_p-1:0] next_res;
    logic [lanes_p-1:0]       next_ovf;
    logic [lanes_p-1:0]       next_zero;
    logic [lanes_p-1:0]       next_neg;

    assign stage2_free = ~s2_valid | yumi_i;
    assign advance     = s1_valid & stage2_free;
    assign ready_o     = ~reset_i & (~s1_valid | stage2_free);
    assign accept      = v_i & ready_o;

    // Opcodes beyond the eight defined ones fall back to add.
    if (op_len_p > 3) begin : g_wide_op
        assign op_code = (|s1_op[op_len_p-1:3]) ? op_add : alu_op_e'(s1_op[2:0]);
    end else begin : g_narrow_op
        assign op_code = alu_op_e'(s1_op[2:0]);
    end

    for (genvar k = 0; k < lanes_p; k++) begin : g_lane
        localparam int msb = vdw_p - 1;

        logic [vdw_p-1:0]   a, b, sum, diff, res, out;
        logic [2*vdw_p-1:0] prod;
        logic               add_ovf, sub_ovf, a_lt_b, ovf;

        assign a       = s1_a[k*vdw_p +: vdw_p];
        assign b       = s1_b[k*vdw_p +: vdw_p];
        assign sum     = a + b;
        assign diff    = a - b;
        assign prod    = {{vdw_p{1'b0}}, a} * {{vdw_p{1'b0}}, b};
        assign add_ovf = (a[msb] == b[msb]) & (sum[msb] != a[msb]);
        assign sub_ovf = (a[msb] != b[msb]) & (diff[msb] != a[msb]);
        assign a_lt_b  = $signed(a) < $signed(b);

        always_comb begin
            // NOTE: defaults first so every path assigns res/ovf and no latch is inferred.
            res = sum;
            ovf = 1'b0;
            case (op_code)
                op_add: begin
                    res = sum;
                    ovf = add_ovf;
`ifdef VECTOR_ALU_SATURATE_EN
                    if (add_ovf) res = a[msb] ? {1'b1, {msb{1'b0}}} : {1'b0, {msb{1'b1}}};
`endif
                end
                op_sub: begin
                    res = diff;
                    ovf = sub_ovf;
`ifdef VECTOR_ALU_SATURATE_EN
                    if (sub_ovf) res = a[msb] ? {1'b1, {msb{1'b0}}} : {1'b0, {msb{1'b1}}};
`endif
                end
                op_mul: begin
                    res = prod[vdw_p-1:0];
                    ovf = |prod[2*vdw_p-1:vdw_p];
                end
                op_min: res = a_lt_b ? a : b;
                op_max: res = a_lt_b ? b : a;
                op_and: res = a & b;
                op_or:  res = a | b;
                op_xor: res = a ^ b;
            endcase
        end

        // Masked-off lanes pass operand A through with all flags cleared.
        assign out                         = s1_mask[k] ? res : a;
        assign next_res[k*vdw_p +: vdw_p]  = out;
        assign next_ovf[k]                 = s1_mask[k] & ovf;
        assign next_zero[k]                = s1_mask[k] & (res == '0);
        assign next_neg[k]                 = s1_mask[k] & res[msb];
    end

    // NOTE: non-blocking assignments for all state so both stages update from the same pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
        if (accept) begin
            s1_a    <= a_i;
            s1_b    <= b_i;
            s1_op   <= op_i;
            s1_mask <= mask_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s2_valid   <= 1'b0;
            result_o   <= '0;
            overflow_o <= '0;
            zero_o     <= '0;
            negative_o <= '0;
        end else if (advance) begin
            s2_valid   <= 1'b1;
            result_o   <= next_res;
            overflow_o <= next_ovf;
            zero_o     <= next_zero;
            negative_o <= next_neg;
        end else if (yumi_i) begin
            s2_valid   <= 1'b0;
        end
    end

    assign v_o = s2_valid;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Directed self-checking bench for vector_alu_pipe at vdw_p=8, lanes_p=4.
// Expectations follow VECTOR_ALU_SATURATE_EN when the macro is defined.
module tb_vector_alu_pipe;

    localparam int W = 8;
    localparam int L = 4;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           v_i = 1'b0;
    logic           ready_o;
    logic [L*W-1:0] a_i = '0;
    logic [L*W-1:0] b_i = '0;
    logic [2:0]     op_i = '0;
    logic [L-1:0]   mask_i = '0;
    logic           v_o;
    logic           yumi_i = 1'b0;
    logic [L*W-1:0] result_o;
    logic [L-1:0]   overflow_o, zero_o, negative_o;

    int tests_run = 0;
    int tests_failed = 0;

    vector_alu_pipe #(.vdw_p(W), .lanes_p(L), .op_len_p(3)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .op_i       (op_i),
        .mask_i     (mask_i),
        .v_o        (v_o),
        .yumi_i     (yumi_i),
        .result_o   (result_o),
        .overflow_o (overflow_o),
        .zero_o     (zero_o),
        .negative_o (negative_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with yumi_i high and verify the two-cycle latency and the result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] mask, input logic [31:0] exp_res,
                          input logic [3:0] exp_ovf, input logic [3:0] exp_zero,
                          input logic [3:0] exp_neg);
        op_i = op; a_i = a; b_i = b; mask_i = mask; v_i = 1'b1;
        #1;
        check({tag, "_ready"}, ready_o, 1);
        tick();
        v_i = 1'b0;
        check({tag, "_lat1"}, v_o, 0);
        tick();
        check({tag, "_v"}, v_o, 1);
        check({tag, "_res"}, result_o, exp_res);
        check({tag, "_ovf"}, overflow_o, exp_ovf);
        check({tag, "_zero"}, zero_o, exp_zero);
        check({tag, "_neg"}, negative_o, exp_neg);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_v", v_o, 0);
        check("rst_res", result_o, 0);
        check("rst_flags", {overflow_o, zero_o, negative_o}, 0);
        check("rst_ready", ready_o, 0);
        reset_i = 1'b0;
        #1;
        check("post_rst_ready", ready_o, 1);

        yumi_i = 1'b1;
`ifdef VECTOR_ALU_SATURATE_EN
        run_op("add", 3'd0, 32'h01FF107F, 32'h01012001, 4'hF, 32'h0200307F, 4'b0001, 4'b0100, 4'b0000);
        run_op("sub_ovf", 3'd1, 32'h80808080, 32'h01010101, 4'hF, 32'h80808080, 4'hF, 4'h0, 4'hF);
`else
        run_op("add", 3'd0, 32'h01FF107F, 32'h01012001, 4'hF, 32'h02003080, 4'b0001, 4'b0100, 4'b0001);
        run_op("sub_ovf", 3'd1, 32'h80808080, 32'h01010101, 4'hF, 32'h7F7F7F7F, 4'hF, 4'h0, 4'h0);
`endif
        run_op("sub_eq", 3'd1, 32'h05050505, 32'h05050505, 4'hF, 32'h00000000, 4'h0, 4'hF, 4'h0);
        run_op("mul", 3'd2, 32'h03031010, 32'h04041010, 4'hF, 32'h0C0C0000, 4'b0011, 4'b0011, 4'h0);
        run_op("min_mask", 3'd3, 32'h80808080, 32'h01010101, 4'h5, 32'h80808080, 4'h0, 4'h0, 4'b0101);
        run_op("max", 3'd4, 32'h807FFF00, 32'h0180FE00, 4'hF, 32'h017FFF00, 4'h0, 4'b0001, 4'b0010);
        run_op("and", 3'd5, 32'hF0CC55AA, 32'h0FAAFF55, 4'hF, 32'h00885500, 4'h0, 4'b1001, 4'b0100);
        run_op("or", 3'd6, 32'hF0CC55AA, 32'h0FAAFF55, 4'hF, 32'hFFEEFFFF, 4'h0, 4'h0, 4'hF);
        run_op("xor", 3'd7, 32'hF0CC55AA, 32'h0FAAFF55, 4'hF, 32'hFF66AAFF, 4'h0, 4'h0, 4'b1011);
        tick();
        check("drain_v", v_o, 0);

        // Back-pressure: three ops, consumer stalled for four cycles.
        yumi_i = 1'b0; op_i = 3'd0; mask_i = 4'hF;
        a_i = 32'h01010101; b_i = 32'h01010101; v_i = 1'b1;
        #1;
        check("stall_ready0", ready_o, 1);
        tick();
        a_i = 32'h10101010; b_i = 32'h01010101;
        check("stall_ready1", ready_o, 1);
        tick();
        a_i = 32'h20202020; b_i = 32'h02020202;
        check("stall_ready2", ready_o, 0);
        check("stall_v", v_o, 1);
        check("stall_resA", result_o, 32'h02020202);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_hold_ready%0d", i), ready_o, 0);
            check($sformatf("stall_hold_res%0d", i), result_o, 32'h02020202);
            check($sformatf("stall_hold_v%0d", i), v_o, 1);
        end
        yumi_i = 1'b1;
        #1;
        check("release_ready", ready_o, 1);
        tick();
        v_i = 1'b0;
        check("order_B_v", v_o, 1);
        check("order_B", result_o, 32'h11111111);
        tick();
        check("order_C_v", v_o, 1);
        check("order_C", result_o, 32'h22222222);
        tick();
        check("order_done", v_o, 0);

        // Reset with two operations in flight.
        yumi_i = 1'b0; op_i = 3'd0;
        a_i = 32'h01010101; b_i = 32'h01010101; v_i = 1'b1;
        tick();
        a_i = 32'h02020202;
        tick();
        v_i = 1'b0;
        check("inflight_v", v_o, 1);
        reset_i = 1'b1;
        tick();
        check("midrst_v", v_o, 0);
        check("midrst_res", result_o, 0);
        check("midrst_flags", {overflow_o, zero_o, negative_o}, 0);
        check("midrst_ready", ready_o, 0);
        reset_i = 1'b0;
        yumi_i = 1'b1;
        #1;
        check("midrst_release_ready", ready_o, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("no_ghost%0d", i), v_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vector_alu_pipe.md
VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 SHALL have parameter vdw_p, default 32, lane data width in bits (>=2).
REQ-002 SHALL have parameter lanes_p, default 4, number of parallel lanes (>=1).
REQ-003 SHALL have parameter op_len_p, default 3, opcode width.
REQ-004 SHALL have port clk_i  input  1  sole clock, all state rising-edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port v_i  input  1  input operation valid.
REQ-007 SHALL have port ready_o  output  1  block can accept an operation this cycle.
REQ-008 SHALL have port a_i  input  lanes_p*vdw_p  operand A, lane k at bits [k*vdw_p +: vdw_p].
REQ-009 SHALL have port b_i  input  lanes_p*vdw_p  operand B, same packing.
REQ-010 SHALL have port op_i  input  op_len_p  opcode.
REQ-011 SHALL have port mask_i  input  lanes_p  per-lane enable, 1 = active.
REQ-012 SHALL have port v_o  output  1  result valid.
REQ-013 SHALL have port yumi_i  input  1  consumer takes the result; legal only while v_o=1.
REQ-014 SHALL have port result_o  output  lanes_p*vdw_p  per-lane result.
REQ-015 SHALL have ports overflow_o, zero_o, negative_o  output  lanes_p each  per-lane flags.

Function
REQ-016 SHALL accept an operation when v_i & ready_o, capturing a_i, b_i, op_i, mask_i into stage 1.
REQ-017 SHALL compute in stage 1 and register results and flags into stage 2, which drives all outputs.
REQ-018 SHALL produce v_o exactly 2 cycles after acceptance when yumi_i has not stalled the pipe.
REQ-019 SHALL sustain one accepted operation per cycle while yumi_i is held high.
REQ-020 SHALL advance stage 1 to stage 2 only when stage 2 is empty or yumi_i=1 that cycle.
REQ-021 SHALL drive ready_o = ~stage1_valid | stage2_free (combinational; no dependence on v_i); capacity 2 operations.
REQ-022 SHALL hold result_o and all flags stable while v_o=1 and yumi_i=0.
REQ-023 SHALL decode opcodes: 0 add, 1 sub (a-b), 2 mul (low vdw_p bits, unsigned), 3 signed min, 4 signed max, 5 and, 6 or, 7 xor.
REQ-024 SHALL set overflow for add/sub to two's-complement signed overflow of the lane.
REQ-025 SHALL set overflow for mul when upper vdw_p bits of the 2*vdw_p unsigned product are non-zero.
REQ-026 SHALL set overflow=0 for opcodes 3-7.
REQ-027 SHALL set zero = (lane result == 0) and negative = lane result MSB.
REQ-028 SHALL, for a lane with mask_i=0, output that lane's a_i unchanged with all three flags 0.
REQ-029 SHALL treat opcodes >7 (op_len_p>3) as add.
REQ-030 SHALL, on simultaneous yumi_i and stage-1 advance, replace stage 2 in the same cycle without a bubble.

Reset
REQ-031 SHALL, while reset_i=1, clear both stage valids, drive v_o=0, result_o=0, all flags 0.
REQ-032 SHALL drive ready_o=0 during reset and ready_o=1 the first cycle after reset deasserts.
REQ-033 SHALL discard in-flight operations on reset mid-operation; none emerge afterwards.

Configuration
REQ-034 SHALL honour macro VECTOR_ALU_SATURATE_EN: defined -> add/sub results clamp to signed max/min on overflow (overflow flag still 1); mul unchanged.
REQ-035 SHALL, without VECTOR_ALU_SATURATE_EN, wrap add/sub results modulo 2^vdw_p.

Verification (vdw_p=8, lanes_p=4)
REQ-036 SHALL cover: add lane0 a=0x7F b=0x01, mask=0xF, yumi_i=1 -> v_o two cycles later, lane0 result 0x80 (0x7F with SATURATE_EN), overflow=1, negative=1 (0 with SATURATE_EN).
REQ-037 SHALL cover: sub a=0x05 b=0x05 all lanes -> results 0x00, zero=0xF, overflow=0x0.
REQ-038 SHALL cover: mul a=0x10 b=0x10 -> result 0x00, overflow=1, zero=1; mul a=0x03 b=0x04 -> 0x0C, overflow=0.
REQ-039 SHALL cover: 3 back-to-back ops, yumi_i=0 for 4 cycles -> ready_o drops after 2 accepts, third held; outputs stable; releasing yumi_i delivers all 3 in order one per cycle.
REQ-040 SHALL cover: min a=0x80 b=0x01 mask=0x5 -> lanes 0,2 result 0x80 negative=1; lanes 1,3 equal a with flags 0.
REQ-041 SHALL cover: reset asserted with 2 ops in flight -> v_o=0 that cycle and no result emerges after reset release.
